// File: rtl/mips_core_pkg.sv
// Shared core types used by the fetch stage.
package mips_core_pkg;

    localparam int ADDR_WIDTH_DEF = 32;

    typedef enum logic {
        F_RUN,
        F_PEND
    } FetchState;

    typedef enum logic [1:0] {
        RSRC_NONE,
        RSRC_DEC,
        RSRC_EX
    } RedirectSrc;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch <-> i-cache / decoder / execute bus. master = fetch_unit side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH_DEF
);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_valid;
    logic                  cache_ready;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic                  squash;
    logic                  dec_jump;
    logic [ADDR_WIDTH-1:0] dec_target;
    logic                  ex_redirect;
    logic [ADDR_WIDTH-1:0] ex_target;

    modport master (
        output pc, pc_valid, dec_pc, squash,
        input  cache_ready, dec_jump, dec_target, ex_redirect, ex_target
    );

    modport slave (
        input  pc, pc_valid, dec_pc, squash,
        output cache_ready, dec_jump, dec_target, ex_redirect, ex_target
    );
endinterface

// File: rtl/fetch_pending_redirect.sv
// Holds a redirect that arrived while fetch was held and merges it with the
// live redirect inputs into a single winner for the current cycle.
// Priority: live ex > pending ex > live dec > pending dec. Latching the winner
// therefore gives "ex overwrites, dec only overwrites a dec" for free.
module fetch_pending_redirect
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_latch,
    input  logic                  i_clear,
    input  logic                  i_ex,
    input  logic [ADDR_WIDTH-1:0] i_ex_target,
    input  logic                  i_dec,
    input  logic [ADDR_WIDTH-1:0] i_dec_target,
    output logic                  o_win_valid,
    output RedirectSrc            o_win_src,
    output logic [ADDR_WIDTH-1:0] o_win_target,
    output logic                  o_win_squash
);

    logic                  r_valid;
    RedirectSrc            r_src;
    logic [ADDR_WIDTH-1:0] r_target;
    logic                  r_squash;

    logic [ADDR_WIDTH-1:0] w_raw_target;

    // Pick this cycle's winning redirect from live inputs and the pending entry.
    always_comb begin
        o_win_valid  = 1'b0;
        o_win_src    = RSRC_NONE;
        w_raw_target = r_target;
        o_win_squash = 1'b0;
        if (i_ex) begin
            o_win_valid  = 1'b1;
            o_win_src    = RSRC_EX;
            w_raw_target = i_ex_target;
            o_win_squash = 1'b1;
        end else if (r_valid && r_src == RSRC_EX) begin
            o_win_valid  = 1'b1;
            o_win_src    = RSRC_EX;
            w_raw_target = r_target;
            o_win_squash = r_squash;
        end else if (i_dec) begin
            o_win_valid  = 1'b1;
            o_win_src    = RSRC_DEC;
            w_raw_target = i_dec_target;
            o_win_squash = 1'b0;
        end else if (r_valid) begin
            o_win_valid  = 1'b1;
            o_win_src    = r_src;
            w_raw_target = r_target;
            o_win_squash = r_squash;
        end
        // Instructions are word aligned; low bits are simply dropped.
        o_win_target = {w_raw_target[ADDR_WIDTH-1:2], 2'b00};
    end

    // Pending entry: cleared when fetch moves, reloaded with the winner while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_src    <= RSRC_NONE;
            r_target <= '0;
            r_squash <= 1'b0;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
            r_src    <= RSRC_NONE;
            r_squash <= 1'b0;
        end else if (i_latch) begin
            r_valid  <= 1'b1;
            r_src    <= o_win_src;
            r_target <= o_win_target;
            r_squash <= o_win_squash;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, tracks the PC leaving the i-cache, and
// applies (possibly deferred) redirects from decode and execute.
module fetch_unit
    import mips_core_pkg::*;
#(
    parameter int                  ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int                  CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_stall,
    fetch_unit_if.master         bus,
    output logic [CNT_WIDTH-1:0] o_redirect_count
);

    FetchState             r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_pc_valid;
    logic [ADDR_WIDTH-1:0] r_dec_pc;
    logic                  r_squash;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_hold;
    logic                  w_hold_pc;
    logic                  w_latch;
    logic                  w_clear;
    logic                  w_apply;
    logic                  w_win_valid;
    RedirectSrc            w_win_src;
    logic [ADDR_WIDTH-1:0] w_win_target;
    logic                  w_win_squash;

    assign w_hold = i_stall | ~bus.cache_ready;
    // The first edge after reset only raises pc_valid so RESET_PC gets fetched.
    assign w_hold_pc = w_hold | ~r_pc_valid;

    fetch_pending_redirect #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pend (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_latch      (w_latch),
        .i_clear      (w_clear),
        .i_ex         (bus.ex_redirect),
        .i_ex_target  (bus.ex_target),
        .i_dec        (bus.dec_jump),
        .i_dec_target (bus.dec_target),
        .o_win_valid  (w_win_valid),
        .o_win_src    (w_win_src),
        .o_win_target (w_win_target),
        .o_win_squash (w_win_squash)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= F_RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state: park redirects while held, release them on the first free cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_clear     = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            F_RUN: begin
                if (w_hold_pc) begin
                    if (w_win_valid) begin
                        w_latch     = 1'b1;
                        w_state_nxt = F_PEND;
                    end
                end else begin
                    w_apply = w_win_valid;
                end
            end
            F_PEND: begin
                if (w_hold_pc) begin
                    w_latch = w_win_valid;
                end else begin
                    w_clear     = 1'b1;
                    w_apply     = w_win_valid;
                    w_state_nxt = F_RUN;
                end
            end
            default: w_state_nxt = F_RUN;
        endcase
    end

    // PC, decode PC, squash flag and redirect counter advance only when not held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_dec_pc   <= RESET_PC;
            r_squash   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_pc_valid <= 1'b1;
            if (!w_hold_pc) begin
                r_pc     <= w_apply ? w_win_target : r_pc + ADDR_WIDTH'(4);
                r_dec_pc <= r_pc;
                // Ex redirect: the PC being replaced is wrong-path and leaves the cache next.
                r_squash <= w_apply & w_win_squash & (w_win_src == RSRC_EX);
                if (w_apply) r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.pc           = r_pc;
    assign bus.pc_valid     = r_pc_valid;
    assign bus.dec_pc       = r_dec_pc;
    assign bus.squash       = r_squash & ~w_hold;
    assign o_redirect_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit. Each row is one cycle of inputs
// plus the outputs expected during that cycle; the driver pushes the
// expectation, the monitor pops and compares it mid-cycle.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] cnt;

    fetch_unit_if #(.ADDR_WIDTH(32)) bus ();

    fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0),
        .CNT_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_stall          (stall),
        .bus              (bus.master),
        .o_redirect_count (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, stl, rdy, dec;
        logic [31:0] dt;
        bit          ex;
        logic [31:0] et;
        logic [31:0] pc;
        bit          pv;
        logic [31:0] dpc;
        bit          sq;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] pc;
        bit          pv;
        logic [31:0] dpc;
        bit          sq;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    task automatic add(bit rst, bit stl, bit rdy, bit dec, logic [31:0] dt, bit ex,
                       logic [31:0] et, logic [31:0] pc, bit pv, logic [31:0] dpc,
                       bit sq, logic [15:0] c);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdy = rdy; v.dec = dec; v.dt = dt;
        v.ex = ex; v.et = et; v.pc = pc; v.pv = pv; v.dpc = dpc; v.sq = sq; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic chk(string name, int row, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL row%0d %s: got %h want %h", row, name, got, want);
        end
    endtask

    // Monitor: compare outputs against the oldest expectation, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc",       e.row, bus.pc,              e.pc);
                chk("pc_valid", e.row, 32'(bus.pc_valid),   32'(e.pv));
                chk("dec_pc",   e.row, bus.dec_pc,          e.dpc);
                chk("squash",   e.row, 32'(bus.squash),     32'(e.sq));
                chk("count",    e.row, 32'(cnt),            32'(e.cnt));
            end
        end
    end

    // Driver
    initial begin
        exp_t e;
        bus.cache_ready = 1'b1;
        bus.dec_jump    = 1'b0;
        bus.dec_target  = '0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = '0;
        //   rst stl rdy dec dt            ex et          pc            pv dpc           sq cnt
        add(0, 0, 1, 0, 0,            0, 0,          32'h0,        0, 32'h0,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h0,        0, 32'h0,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h0,        1, 32'h0,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h4,        1, 32'h0,        0, 0);
        add(1, 0, 1, 1, 32'h100,      0, 0,          32'h8,        1, 32'h4,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h100,      1, 32'h8,        0, 1);
        add(1, 0, 1, 1, 32'h200,      0, 0,          32'h104,      1, 32'h100,      0, 1);
        add(1, 0, 1, 0, 0,            0, 0,          32'h200,      1, 32'h104,      0, 2);
        add(1, 0, 1, 1, 32'h108,      0, 0,          32'h204,      1, 32'h200,      0, 2);
        add(1, 0, 1, 0, 0,            1, 32'h40,     32'h108,      1, 32'h204,      0, 3);
        add(1, 0, 1, 0, 0,            0, 0,          32'h40,       1, 32'h108,      1, 4);
        add(1, 0, 1, 0, 0,            0, 0,          32'h44,       1, 32'h40,       0, 4);
        add(1, 1, 1, 0, 0,            1, 32'h80,     32'h48,       1, 32'h44,       0, 4);
        add(1, 1, 1, 1, 32'h90,       0, 0,          32'h48,       1, 32'h44,       0, 4);
        add(1, 1, 1, 0, 0,            0, 0,          32'h48,       1, 32'h44,       0, 4);
        add(1, 0, 1, 0, 0,            0, 0,          32'h48,       1, 32'h44,       0, 4);
        add(1, 0, 1, 0, 0,            0, 0,          32'h80,       1, 32'h48,       1, 5);
        add(1, 0, 1, 1, 32'h400,      1, 32'h300,    32'h84,       1, 32'h80,       0, 5);
        add(1, 0, 0, 0, 0,            0, 0,          32'h300,      1, 32'h84,       0, 6);
        add(1, 0, 0, 0, 0,            0, 0,          32'h300,      1, 32'h84,       0, 6);
        add(1, 0, 1, 0, 0,            0, 0,          32'h300,      1, 32'h84,       1, 6);
        add(1, 0, 1, 1, 32'h503,      0, 0,          32'h304,      1, 32'h300,      0, 6);
        add(1, 0, 1, 1, 32'hFFFFFFFC, 0, 0,          32'h500,      1, 32'h304,      0, 7);
        add(1, 0, 1, 0, 0,            0, 0,          32'hFFFFFFFC, 1, 32'h500,      0, 8);
        add(1, 0, 1, 0, 0,            0, 0,          32'h0,        1, 32'hFFFFFFFC, 0, 8);
        add(1, 1, 1, 0, 0,            1, 32'h700,    32'h4,        1, 32'h0,        0, 8);
        add(1, 1, 1, 0, 0,            0, 0,          32'h4,        1, 32'h0,        0, 8);
        add(0, 1, 1, 0, 0,            0, 0,          32'h0,        0, 32'h0,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h0,        0, 32'h0,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h0,        1, 32'h0,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h4,        1, 32'h0,        0, 0);
        add(1, 0, 1, 0, 0,            0, 0,          32'h8,        1, 32'h4,        0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n           = vecs[i].rst;
            stall           = vecs[i].stl;
            bus.cache_ready = vecs[i].rdy;
            bus.dec_jump    = vecs[i].dec;
            bus.dec_target  = vecs[i].dt;
            bus.ex_redirect = vecs[i].ex;
            bus.ex_target   = vecs[i].et;
            e.row = i; e.pc = vecs[i].pc; e.pv = vecs[i].pv;
            e.dpc = vecs[i].dpc; e.sq = vecs[i].sq; e.cnt = vecs[i].cnt;
            sb.push_back(e);
        end
        @(negedge clk);
        #4;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not finish, want finish");
            $fatal(1, "timeout");
        end
    end

endmodule
